// File: rtl/sipo_in_pkg.sv
// Shared definitions for the serial-in/parallel-out input buffer and its PISO twin.
// Build option: SIPO_IN_DBUF_EN (separate output register, fill continues while a frame is held).
package sipo_in_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_NUM_TAPS = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } sipo_state_e;

    function automatic int cnt_w(input int num_taps);
        return $clog2(num_taps);
    endfunction

endpackage

// File: rtl/sipo_in_ctrl.sv
// Word counter, FILL/HOLD state, ready/valid handshake and sticky overflow flag.
// Build option: SIPO_IN_DBUF_EN changes only the READY_IN rule.
module sipo_in_ctrl
    import sipo_in_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS
) (
    input  logic clk,
    input  logic srst,
    input  logic en_i,
    input  logic ack_i,
    output logic ready_o,
    output logic valid_o,
    output logic ovf_o,
    output logic accept_o,
    output logic last_o
);

    localparam int CNT_W = cnt_w(NUM_TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TAPS - 1);

    sipo_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             at_last;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_FILL;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        at_last  = (count_q == LAST_CNT);
`ifdef SIPO_IN_DBUF_EN
        // Only the word that would overwrite an unconsumed output frame has to wait.
        ready_o  = !(at_last && (state_q == ST_HOLD) && !ack_i);
`else
        ready_o  = (state_q == ST_FILL);
`endif
        accept_o = en_i && ready_o;
        last_o   = accept_o && at_last;

        if (accept_o) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
        if (en_i && !ready_o) begin
            ovf_d = 1'b1;
        end
        // A completing frame wins over an ack of the previous one: no bubble.
        if (last_o) begin
            state_d = ST_HOLD;
        end else if ((state_q == ST_HOLD) && ack_i) begin
            state_d = ST_FILL;
        end
    end

    assign valid_o = (state_q == ST_HOLD);
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/sipo_in.sv
// Serial-in, parallel-out input buffer: shifts WIDTH-bit words into NUM_TAPS taps.
// Build option: SIPO_IN_DBUF_EN adds a frame output register loaded on the final word.
module sipo_in
    import sipo_in_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_TAPS = DEF_NUM_TAPS
) (
    input  logic                      CLKEXT,
    input  logic                      CLR_SIPO_IN,
    input  logic                      EN_SIPO_IN,
    input  logic [WIDTH-1:0]          DATA_IN,
    output logic                      READY_IN,
    output logic [WIDTH*NUM_TAPS-1:0] DATA_OUT,
    output logic                      VALID_OUT,
    input  logic                      ACK_OUT,
    output logic                      OVF_SIPO_IN
);

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] tap_q [NUM_TAPS];

    sipo_in_ctrl #(
        .NUM_TAPS (NUM_TAPS)
    ) u_ctrl (
        .clk      (CLKEXT),
        .srst     (CLR_SIPO_IN),
        .en_i     (EN_SIPO_IN),
        .ack_i    (ACK_OUT),
        .ready_o  (READY_IN),
        .valid_o  (VALID_OUT),
        .ovf_o    (OVF_SIPO_IN),
        .accept_o (accept),
        .last_o   (last)
    );

`ifdef SIPO_IN_DBUF_EN
    logic [WIDTH*NUM_TAPS-1:0] out_q;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            logic [WIDTH-1:0] shift_in;
            if (gi == 0) begin : g_head
                assign shift_in = DATA_IN;
            end else begin : g_body
                assign shift_in = tap_q[gi-1];
            end

            always_ff @(posedge CLKEXT) begin
                if (CLR_SIPO_IN) begin
                    tap_q[gi] <= '0;
                end else if (accept) begin
                    tap_q[gi] <= shift_in;
                end
            end

`ifdef SIPO_IN_DBUF_EN
            // Snapshot what the taps will hold after this final shift.
            always_ff @(posedge CLKEXT) begin
                if (CLR_SIPO_IN) begin
                    out_q[gi*WIDTH +: WIDTH] <= '0;
                end else if (last) begin
                    out_q[gi*WIDTH +: WIDTH] <= shift_in;
                end
            end
            assign DATA_OUT[gi*WIDTH +: WIDTH] = out_q[gi*WIDTH +: WIDTH];
`else
            assign DATA_OUT[gi*WIDTH +: WIDTH] = tap_q[gi];
`endif
        end
    endgenerate

endmodule
